pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller. Drives Stall/Flush for the four pipeline registers
//  (if_reg, id_reg, ex_reg, mem_reg) and the fetch-PC redirect. Handles memory-busy
//  freeze, load-use interlock, taken branches, exceptions/interrupts and ERET.
//  Holds EPC, exception cause, the interrupt-enable flag and a stall-cycle counter.
// PARAMETERS
//  ADDR_W      30      word-address width (PC, branch target, EPC)
//  REG_W       5       GPR address width
//  EXP_W       3       exception-code width; code 0 = no exception
//  CNT_W       16      stall-counter width
//  EXP_VECTOR  30'h10  word address loaded into PC on trap
//  IRQ_CODE    3'h1    cause recorded for an external interrupt
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  IFEn       in   1       if_reg holds a valid instruction (being decoded)
//  RaAddr     in   REG_W   decoder source A address; RaUse in 1: source A is read
//  RbAddr     in   REG_W   decoder source B address; RbUse in 1: source B is read
//  IDEn       in   1       id_reg valid; IDIsLoad in 1: id_reg holds a load
//  IDDstAddr  in   REG_W   id_reg destination; IDGPRWE_ in 1: active-low GPR write enable
//  BrTaken    in   1       decoder resolved a taken branch; BrTarget in ADDR_W: target
//  EXEn       in   1       ex_reg valid; EXPC in ADDR_W: PC of ex_reg instruction
//  EXExpCode  in   EXP_W   exception code of ex_reg instruction; EXEret in 1: ex_reg is ERET
//  MemBusy    in   1       memory stage not ready this cycle
//  IrqReq     in   1       level interrupt request
//  IFStall/IDStall/EXStall/MEMStall   out 1 each   hold the register
//  IFFlush/IDFlush/EXFlush/MEMFlush   out 1 each   load a bubble (ignored by reg while stalled)
//  PCLoad     out  1       fetch PC loads NewPC at next edge; NewPC out ADDR_W
//  EPC        out  ADDR_W  exception return address (registered)
//  ExpCause   out  EXP_W   last trap cause (registered)
//  IntEn      out  1       interrupts enabled (registered)
//  StallCnt   out  CNT_W   saturating count of cycles with IFStall=1
// BEHAVIOUR
//  - Reset: state=RUN, EPC=0, ExpCause=0, IntEn=1, StallCnt=0. While reset is high,
//    all stall, flush and PCLoad outputs = 0 and NewPC = 0.
//  - Stall/Flush/PCLoad/NewPC are combinational from inputs and state. Defaults are
//    all 0 and NewPC=0. Registered outputs update at the edge after their cause.
//  - FSM states: RUN, TRAP, ERET. Priority in RUN, highest first:
//    1 MemBusy: all four Stall=1, no flush, PCLoad=0, state held.
//    2 Trap event: EXEn & EXExpCode!=0, or IrqReq & IntEn & EXEn.
//      All four Flush=1. EPC<=EXPC. ExpCause<=EXExpCode, or IRQ_CODE if EXExpCode==0.
//      IntEn<=0. ->TRAP. Synchronous exception outranks the IRQ in the same cycle.
//    3 EXEn & EXEret: IF/ID/EX Flush=1, ->ERET.
//    4 Load-use: IDEn & IDIsLoad & !IDGPRWE_ & IDDstAddr!=0 & IFEn &
//      ((RaUse & RaAddr==IDDstAddr) | (RbUse & RbAddr==IDDstAddr)).
//      Response: IFStall=1, IDFlush=1; EX/MEM advance. BrTaken is ignored this cycle.
//    5 IFEn & BrTaken: PCLoad=1, NewPC=BrTarget, IFFlush=1.
//  - TRAP state: PCLoad=1, NewPC=EXP_VECTOR, IFFlush=1, then ->RUN.
//    If MemBusy: all Stall=1, PCLoad=0, remain in TRAP.
//  - ERET state: PCLoad=1, NewPC=EPC, IFFlush=1, IntEn<=1, then ->RUN.
//    MemBusy is handled as in TRAP.
//  - Trap latency: detect edge + 1 cycle, then fetch from the vector. ERET latency is the same.
//  - IrqReq is ignored in TRAP/ERET and while IntEn=0. It is sampled only when not MemBusy.
//  - StallCnt: +1 each cycle IFStall=1 and not reset; holds at 2^CNT_W-1.
//  - Reset mid-TRAP/ERET: returns to RUN, no redirect issued.
// TESTING
//  - Load-use: IDIsLoad=1, IDGPRWE_=0, IDDstAddr=5, RaUse=1, RaAddr=5, BrTaken=1 ->
//    IFStall=1, IDFlush=1, PCLoad=0; StallCnt 0->1.
//  - Branch: BrTaken=1, BrTarget=30'h123, no hazard -> PCLoad=1, NewPC=30'h123,
//    IFFlush=1, no stall.
//  - Exception: EXEn=1, EXExpCode=3'h2, EXPC=30'h40 -> all Flush=1.
//    Next cycle: EPC=30'h40, ExpCause=2, IntEn=0, PCLoad=1, NewPC=30'h10. Then RUN.
//  - MemBusy held 3 cycles with EXExpCode=2 pending -> 3 cycles all Stall=1 and no trap.
//    Trap fires on the 4th cycle; StallCnt=3.
//  - Trap then ERET in EX -> next cycle NewPC=30'h40, PCLoad=1, IntEn=1.
//    IrqReq=1 during TRAP is ignored.
//  - Simultaneous EXExpCode=2 and IrqReq=1 -> ExpCause=2. StallCnt saturates at
//    16'hFFFF under continuous MemBusy.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - central pipeline controller.
//
// Generates stall/flush for if_reg, id_reg, ex_reg and mem_reg plus the
// fetch-PC redirect. Handles the memory-busy freeze, load-use interlock,
// taken branches, exceptions/interrupts and ERET. Keeps EPC, the last trap
// cause, the interrupt-enable flag and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   IFEn, RaAddr/RaUse, RbAddr/RbUse  decode-stage instruction and its sources
//   IDEn, IDIsLoad, IDDstAddr, IDGPRWE_  id_reg instruction (GPR WE active low)
//   BrTaken, BrTarget               resolved taken branch and its target
//   EXEn, EXPC, EXExpCode, EXEret   ex_reg instruction, PC, exception, ERET
//   MemBusy, IrqReq                 memory not ready, level interrupt request
//   IF/ID/EX/MEMStall, *Flush       per-register hold / bubble controls
//   PCLoad, NewPC                   fetch-PC redirect
//   EPC, ExpCause, IntEn, StallCnt  registered status
module pipe_ctrl #(
    parameter int unsigned       ADDR_W     = 30,
    parameter int unsigned       REG_W      = 5,
    parameter int unsigned       EXP_W      = 3,
    parameter int unsigned       CNT_W      = 16,
    parameter logic [ADDR_W-1:0] EXP_VECTOR = 30'h10,
    parameter logic [EXP_W-1:0]  IRQ_CODE   = 3'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IFEn,
    input  logic [REG_W-1:0]  RaAddr,
    input  logic              RaUse,
    input  logic [REG_W-1:0]  RbAddr,
    input  logic              RbUse,
    input  logic              IDEn,
    input  logic              IDIsLoad,
    input  logic [REG_W-1:0]  IDDstAddr,
    input  logic              IDGPRWE_,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrTarget,
    input  logic              EXEn,
    input  logic [ADDR_W-1:0] EXPC,
    input  logic [EXP_W-1:0]  EXExpCode,
    input  logic              EXEret,
    input  logic              MemBusy,
    input  logic              IrqReq,
    output logic              IFStall,
    output logic              IDStall,
    output logic              EXStall,
    output logic              MEMStall,
    output logic              IFFlush,
    output logic              IDFlush,
    output logic              EXFlush,
    output logic              MEMFlush,
    output logic              PCLoad,
    output logic [ADDR_W-1:0] NewPC,
    output logic [ADDR_W-1:0] EPC,
    output logic [EXP_W-1:0]  ExpCause,
    output logic              IntEn,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_ERET = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [EXP_W-1:0]    cause_q, cause_d;
    logic                inten_q, inten_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                trap_ev_s;
    logic                eret_ev_s;
    logic                load_use_s;

    // An IRQ only counts when it can be attached to a valid EX instruction.
    assign trap_ev_s  = EXEn & ((EXExpCode != '0) | (IrqReq & inten_q));
    assign eret_ev_s  = EXEn & EXEret;
    assign load_use_s = IDEn & IDIsLoad & ~IDGPRWE_ & (IDDstAddr != '0) & IFEn &
                        ((RaUse & (RaAddr == IDDstAddr)) |
                         (RbUse & (RbAddr == IDDstAddr)));

    // State and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            epc_q   <= '0;
            cause_q <= '0;
            inten_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            inten_q <= inten_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (MemBusy) begin
                    state_d = S_RUN;
                end else if (trap_ev_s) begin
                    state_d = S_TRAP;
                end else if (eret_ev_s) begin
                    state_d = S_ERET;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_TRAP, S_ERET: begin
                if (MemBusy) begin
                    state_d = state_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Next values of EPC / cause / interrupt enable / stall counter.
    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        inten_d = inten_q;
        cnt_d   = cnt_q;
        if ((state_q == S_RUN) && !MemBusy && trap_ev_s) begin
            epc_d   = EXPC;
            cause_d = (EXExpCode != '0) ? EXExpCode : IRQ_CODE;
            inten_d = 1'b0;
        end else if ((state_q == S_ERET) && !MemBusy) begin
            inten_d = 1'b1;
        end else begin
            inten_d = inten_q;
        end
        if (IFStall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall / flush / redirect outputs; all quiet while reset is asserted.
    always_comb begin
        IFStall  = 1'b0;
        IDStall  = 1'b0;
        EXStall  = 1'b0;
        MEMStall = 1'b0;
        IFFlush  = 1'b0;
        IDFlush  = 1'b0;
        EXFlush  = 1'b0;
        MEMFlush = 1'b0;
        PCLoad   = 1'b0;
        NewPC    = '0;
        if (reset) begin
            PCLoad = 1'b0;
        end else if (MemBusy) begin
            // Memory freeze wins in every state.
            IFStall  = 1'b1;
            IDStall  = 1'b1;
            EXStall  = 1'b1;
            MEMStall = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (trap_ev_s) begin
                        IFFlush  = 1'b1;
                        IDFlush  = 1'b1;
                        EXFlush  = 1'b1;
                        MEMFlush = 1'b1;
                    end else if (eret_ev_s) begin
                        IFFlush = 1'b1;
                        IDFlush = 1'b1;
                        EXFlush = 1'b1;
                    end else if (load_use_s) begin
                        // Hold decode, bubble into EX; a branch seen now is re-resolved later.
                        IFStall = 1'b1;
                        IDFlush = 1'b1;
                    end else if (IFEn && BrTaken) begin
                        PCLoad  = 1'b1;
                        NewPC   = BrTarget;
                        IFFlush = 1'b1;
                    end else begin
                        PCLoad = 1'b0;
                    end
                end
                S_TRAP: begin
                    PCLoad  = 1'b1;
                    NewPC   = EXP_VECTOR;
                    IFFlush = 1'b1;
                end
                S_ERET: begin
                    PCLoad  = 1'b1;
                    NewPC   = epc_q;
                    IFFlush = 1'b1;
                end
                default: PCLoad = 1'b0;
            endcase
        end
    end

    assign EPC      = epc_q;
    assign ExpCause = cause_q;
    assign IntEn    = inten_q;
    assign StallCnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int AW = 30;
    localparam int RW = 5;
    localparam int EW = 3;
    localparam int CW = 6;   // narrow counter so saturation is reachable quickly
    localparam logic [AW-1:0] VEC = 30'h10;

    logic          clk = 1'b0;
    logic          reset;
    logic          IFEn, RaUse, RbUse, IDEn, IDIsLoad, IDGPRWE_;
    logic [RW-1:0] RaAddr, RbAddr, IDDstAddr;
    logic          BrTaken, EXEn, EXEret, MemBusy, IrqReq;
    logic [AW-1:0] BrTarget, EXPC;
    logic [EW-1:0] EXExpCode;
    logic          IFStall, IDStall, EXStall, MEMStall;
    logic          IFFlush, IDFlush, EXFlush, MEMFlush, PCLoad, IntEn;
    logic [AW-1:0] NewPC, EPC;
    logic [EW-1:0] ExpCause;
    logic [CW-1:0] StallCnt;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .IFEn(IFEn), .RaAddr(RaAddr), .RaUse(RaUse),
        .RbAddr(RbAddr), .RbUse(RbUse), .IDEn(IDEn), .IDIsLoad(IDIsLoad),
        .IDDstAddr(IDDstAddr), .IDGPRWE_(IDGPRWE_), .BrTaken(BrTaken),
        .BrTarget(BrTarget), .EXEn(EXEn), .EXPC(EXPC), .EXExpCode(EXExpCode),
        .EXEret(EXEret), .MemBusy(MemBusy), .IrqReq(IrqReq),
        .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MEMStall(MEMStall),
        .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush),
        .PCLoad(PCLoad), .NewPC(NewPC), .EPC(EPC), .ExpCause(ExpCause),
        .IntEn(IntEn), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural status plus "redirect still owed".
    logic [AW-1:0] m_epc;
    logic [EW-1:0] m_cause;
    logic          m_ie;
    int            m_cnt;
    int            m_owed;     // 0 none, 1 vector fetch owed, 2 return-to-EPC owed
    int            m_dec;      // decision taken this cycle: 1 trap, 2 eret
    logic [3:0]    e_stall, e_flush;   // {IF,ID,EX,MEM}
    logic          e_pcl;
    logic [AW-1:0] e_npc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        reset = 1'b0; IFEn = 1'b0; RaUse = 1'b0; RbUse = 1'b0; IDEn = 1'b0;
        IDIsLoad = 1'b0; IDGPRWE_ = 1'b1; RaAddr = '0; RbAddr = '0; IDDstAddr = '0;
        BrTaken = 1'b0; EXEn = 1'b0; EXEret = 1'b0; MemBusy = 1'b0; IrqReq = 1'b0;
        BrTarget = '0; EXPC = '0; EXExpCode = '0;
    endtask

    // Expected combinational response from the current inputs and model status.
    task automatic model_comb();
        bit hazard;
        e_stall = 4'b0000; e_flush = 4'b0000; e_pcl = 1'b0; e_npc = '0; m_dec = 0;
        hazard = IDEn && IDIsLoad && !IDGPRWE_ && IDDstAddr != 0 && IFEn &&
                 ((RaUse && RaAddr == IDDstAddr) || (RbUse && RbAddr == IDDstAddr));
        if (reset) begin
            e_pcl = 1'b0;
        end else if (MemBusy) begin
            e_stall = 4'b1111;
        end else if (m_owed != 0) begin
            e_pcl = 1'b1; e_flush = 4'b1000;
            e_npc = (m_owed == 1) ? VEC : m_epc;
        end else if (EXEn && (EXExpCode != 0 || (IrqReq && m_ie))) begin
            e_flush = 4'b1111; m_dec = 1;
        end else if (EXEn && EXEret) begin
            e_flush = 4'b1110; m_dec = 2;
        end else if (hazard) begin
            e_stall = 4'b1000; e_flush = 4'b0100;
        end else if (IFEn && BrTaken) begin
            e_pcl = 1'b1; e_npc = BrTarget; e_flush = 4'b1000;
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            m_epc = '0; m_cause = '0; m_ie = 1'b1; m_cnt = 0; m_owed = 0;
        end else begin
            if (e_stall[3] && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_owed != 0) begin
                if (!MemBusy) begin
                    if (m_owed == 2) m_ie = 1'b1;
                    m_owed = 0;
                end
            end else if (m_dec == 1) begin
                m_epc = EXPC;
                m_cause = (EXExpCode != 0) ? EXExpCode : 3'h1;
                m_ie = 1'b0;
                m_owed = 1;
            end else if (m_dec == 2) begin
                m_owed = 2;
            end
        end
    endtask

    // Settle after the inputs change, then compare every output with the model.
    task automatic tick();
        #1;
        model_comb();
        chk("ctrl", {55'd0, IFStall, IDStall, EXStall, MEMStall,
                     IFFlush, IDFlush, EXFlush, MEMFlush, PCLoad},
                    {55'd0, e_stall, e_flush, e_pcl});
        chk("newpc", {34'd0, NewPC}, {34'd0, e_npc});
        chk("status", {24'd0, EPC, ExpCause, IntEn, StallCnt},
                      {24'd0, m_epc, m_cause, m_ie, CW'(m_cnt)});
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr(); reset = 1'b1; tick(); adv(); reset = 1'b0;
    endtask

    initial begin
        m_epc = '0; m_cause = '0; m_ie = 1'b1; m_cnt = 0; m_owed = 0; m_dec = 0;
        clr();
        reset = 1'b1;
        @(negedge clk);
        tick(); adv();
        tick();
        chk("rst_epc", {34'd0, EPC}, 64'd0);
        chk("rst_inten", {63'd0, IntEn}, 64'd1);
        chk("rst_cnt", {58'd0, StallCnt}, 64'd0);
        chk("rst_pcload", {63'd0, PCLoad}, 64'd0);
        adv();

        // Load-use with a taken branch also present.
        clr();
        IFEn = 1'b1; IDEn = 1'b1; IDIsLoad = 1'b1; IDGPRWE_ = 1'b0; IDDstAddr = 5'd5;
        RaUse = 1'b1; RaAddr = 5'd5; BrTaken = 1'b1; BrTarget = 30'h77;
        tick();
        chk("lu_ifstall", {63'd0, IFStall}, 64'd1);
        chk("lu_idflush", {63'd0, IDFlush}, 64'd1);
        chk("lu_pcload", {63'd0, PCLoad}, 64'd0);
        adv();
        clr(); tick();
        chk("lu_cnt", {58'd0, StallCnt}, 64'd1);
        adv();

        // Plain branch.
        IFEn = 1'b1; BrTaken = 1'b1; BrTarget = 30'h123;
        tick();
        chk("br_pcload", {63'd0, PCLoad}, 64'd1);
        chk("br_newpc", {34'd0, NewPC}, 64'h123);
        chk("br_flush_stall", {59'd0, IFFlush, IFStall, IDStall, EXStall, MEMStall}, 64'h10);
        adv();

        // Exception, with an IRQ raised during TRAP.
        clr(); EXEn = 1'b1; EXExpCode = 3'h2; EXPC = 30'h40;
        tick();
        chk("exc_flush", {60'd0, IFFlush, IDFlush, EXFlush, MEMFlush}, 64'hF);
        adv();
        clr(); IrqReq = 1'b1; tick();
        chk("trap_epc", {34'd0, EPC}, 64'h40);
        chk("trap_cause", {61'd0, ExpCause}, 64'd2);
        chk("trap_inten", {63'd0, IntEn}, 64'd0);
        chk("trap_redirect", {33'd0, PCLoad, NewPC}, {33'd1, 30'h10});
        adv();
        clr(); tick();
        chk("trap_back_run", {63'd0, PCLoad}, 64'd0);
        adv();

        // ERET in EX.
        EXEn = 1'b1; EXEret = 1'b1; tick(); adv();
        clr(); tick();
        chk("eret_redirect", {33'd0, PCLoad, NewPC}, {33'd1, 30'h40});
        adv();
        tick();
        chk("eret_inten", {63'd0, IntEn}, 64'd1);
        adv();

        // Pending exception frozen by MemBusy for 3 cycles.
        do_reset();
        EXEn = 1'b1; EXExpCode = 3'h2; EXPC = 30'h55; MemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_stall", {56'd0, IFStall, IDStall, EXStall, MEMStall,
                               IFFlush, IDFlush, EXFlush, MEMFlush}, 64'hF0);
            adv();
        end
        MemBusy = 1'b0; tick();
        chk("busy_then_trap", {60'd0, IFFlush, IDFlush, EXFlush, MEMFlush}, 64'hF);
        chk("busy_cnt", {58'd0, StallCnt}, 64'd3);
        adv();
        clr(); tick();
        chk("busy_vector", {33'd0, PCLoad, NewPC}, {33'd1, 30'h10});
        adv();

        // Exception and IRQ together, then IRQ alone.
        do_reset();
        EXEn = 1'b1; EXExpCode = 3'h2; IrqReq = 1'b1; tick(); adv();
        clr(); tick();
        chk("exc_over_irq", {61'd0, ExpCause}, 64'd2);
        adv();
        do_reset();
        EXEn = 1'b1; IrqReq = 1'b1; EXPC = 30'h99; tick(); adv();
        clr(); tick();
        chk("irq_cause", {61'd0, ExpCause}, 64'd1);
        adv();

        // Counter saturation.
        do_reset();
        MemBusy = 1'b1;
        for (int i = 0; i < 70; i++) begin tick(); adv(); end
        clr(); tick();
        chk("cnt_sat", {58'd0, StallCnt}, 64'd63);
        adv();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            IFEn      = ($urandom_range(0, 99) < 80);
            IDEn      = ($urandom_range(0, 99) < 80);
            IDIsLoad  = ($urandom_range(0, 99) < 50);
            IDGPRWE_  = ($urandom_range(0, 99) < 25);
            IDDstAddr = RW'($urandom_range(0, 3));
            RaAddr    = RW'($urandom_range(0, 3));
            RbAddr    = RW'($urandom_range(0, 3));
            RaUse     = $urandom_range(0, 1);
            RbUse     = $urandom_range(0, 1);
            BrTaken   = ($urandom_range(0, 99) < 30);
            BrTarget  = AW'($urandom);
            EXEn      = ($urandom_range(0, 99) < 80);
            EXPC      = AW'($urandom);
            EXExpCode = ($urandom_range(0, 99) < 10) ? EW'($urandom_range(1, 7)) : 3'h0;
            EXEret    = ($urandom_range(0, 99) < 10);
            MemBusy   = ($urandom_range(0, 99) < 20);
            IrqReq    = ($urandom_range(0, 99) < 30);
            tick();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
